// File: rtl/dma_ahb_writer.sv
// dma_ahb_writer: destination-side DMA engine. Pops words from the channel
// FIFO and issues them as single AHB-Lite write beats to an incrementing or
// fixed address until the programmed count completes or an ERROR arrives.
//
// Handshakes:
//   - FIFO: a word is consumed on each rising edge where fifo_read_o = 1.
//     fifo_read_o is high only when a NONSEQ address phase is accepted, so
//     a pop always corresponds to an issued beat.
//   - AHB: an address phase is accepted on an edge with htrans_o = NONSEQ
//     and hready_i = 1. The pending data phase completes on the next edge
//     with hready_i = 1; an ERROR response is taken on that edge if hresp_i = 1.
module dma_ahb_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  incr_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic                  hready_i,
  input  logic                  hresp_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [1:0]            state_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [2:0]            HSIZE    = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  localparam logic [1:0]            HT_IDLE   = 2'b00;
  localparam logic [1:0]            HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  incr_q, incr_d;
  logic [LEN_WIDTH-1:0]  issue_q, issue_d;
  logic [LEN_WIDTH-1:0]  data_cnt_q, data_cnt_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic nonseq;
  logic accept;
  logic complete;
  logic err_end;

  // Bus-phase qualifiers derived from state and live bus/FIFO inputs.
  always_comb begin
    nonseq   = (state_q == S_XFER) && (issue_q != '0) && !fifo_empty_i && !hresp_i;
    accept   = nonseq && hready_i;
    complete = pend_q && hready_i;
    err_end  = complete && hresp_i;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      incr_q     <= 1'b0;
      issue_q    <= '0;
      data_cnt_q <= '0;
      pend_q     <= 1'b0;
      hwdata_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      incr_q     <= incr_d;
      issue_q    <= issue_d;
      data_cnt_q <= data_cnt_d;
      pend_q     <= pend_d;
      hwdata_q   <= hwdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: start handling, beat issue, data-phase tracking, abort on ERROR.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    incr_d     = incr_q;
    issue_d    = issue_q;
    data_cnt_d = data_cnt_q;
    pend_d     = pend_q;
    hwdata_d   = hwdata_q;
    done_d     = 1'b0;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          error_d = 1'b0;
          if (len_i == '0) begin
            // Empty request completes immediately without touching the bus.
            done_d = 1'b1;
          end else begin
            addr_d     = dst_addr_i;
            incr_d     = incr_i;
            issue_d    = len_i;
            data_cnt_d = len_i;
            pend_d     = 1'b0;
            state_d    = S_XFER;
          end
        end
      end

      S_XFER, S_DRAIN: begin
        if (err_end) begin
          // Remaining words stay in the FIFO for the channel controller to flush.
          error_d    = 1'b1;
          done_d     = 1'b1;
          pend_d     = 1'b0;
          issue_d    = '0;
          data_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          if (complete) begin
            data_cnt_d = data_cnt_q - LEN_WIDTH'(1);
          end
          if (accept) begin
            hwdata_d = fifo_data_i;
            issue_d  = issue_q - LEN_WIDTH'(1);
            if (incr_q) begin
              addr_d = addr_q + ADDR_INC;
            end
          end
          pend_d = accept || (pend_q && !hready_i);
          if ((state_q == S_XFER) && accept && (issue_q == LEN_WIDTH'(1))) begin
            state_d = S_DRAIN;
          end
          if ((state_q == S_DRAIN) && complete && (data_cnt_q == LEN_WIDTH'(1))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output mapping.
  always_comb begin
    fifo_read_o = accept;
    htrans_o    = nonseq ? HT_NONSEQ : HT_IDLE;
    haddr_o     = addr_q;
    hwdata_o    = hwdata_q;
    busy_o      = (state_q != S_IDLE);
    hwrite_o    = (state_q != S_IDLE);
    hsize_o     = HSIZE;
    hburst_o    = 3'b000;
    done_o      = done_q;
    error_o     = error_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_dma_ahb_writer.sv
// Bench for dma_ahb_writer: a driver feeds a FIFO model and AHB response
// masks per transfer and queues hand-computed expectations; a negedge
// monitor pops and compares them as the DUT presents beats and completions.
module tb_dma_ahb_writer;

  logic        clk;
  logic        areset;
  logic        start_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        incr_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_read_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  state_o;

  dma_ahb_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .areset       (areset),
    .start_i      (start_i),
    .dst_addr_i   (dst_addr_i),
    .len_i        (len_i),
    .incr_i       (incr_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_read_o  (fifo_read_o),
    .haddr_o      (haddr_o),
    .htrans_o     (htrans_o),
    .hwrite_o     (hwrite_o),
    .hsize_o      (hsize_o),
    .hburst_o     (hburst_o),
    .hwdata_o     (hwdata_o),
    .hready_i     (hready_i),
    .hresp_i      (hresp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_done_q[$];   // cycle index after the start edge where done_o is high
  logic [31:0] exp_err_q[$];
  logic [31:0] exp_pops_q[$];
  logic [31:0] fifo_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pop_total  = 0;
  int done_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, predicts what the next rising edge commits.
  logic tb_pend = 1'b0;
  logic active  = 1'b0;
  int   rel     = 0;
  int   xfer_pops = 0;

  always @(negedge clk) begin
    logic acc;
    if (!areset) begin
      tb_pend = 1'b0;
      active  = 1'b0;
      check("reset_outputs",
            {fifo_read_o, htrans_o, haddr_o, hwdata_o, busy_o, done_o, error_o, hwrite_o, state_o},
            {1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      check("hsize_hburst", {hsize_o, hburst_o}, {3'd2, 3'd0});
    end else begin
      if (active) begin
        rel++;
        if (rel > 60) begin
          n_checks++;
          n_fail++;
          $display("FAIL timeout actual=no_done required=done_within_60");
          active = 1'b0;
        end
      end
      if (start_i && !busy_o) begin
        active    = 1'b1;
        rel       = -1;
        xfer_pops = 0;
      end

      acc = (htrans_o == 2'b10) && hready_i;
      if (hresp_i || fifo_empty_i || !busy_o) check("htrans_idle", htrans_o, 2'b00);
      check("hwrite_vs_busy", hwrite_o, busy_o);
      if (acc || fifo_read_o) check("pop_vs_accept", fifo_read_o, acc);
      if (fifo_read_o) begin
        pop_total++;
        xfer_pops++;
      end
      if (active && rel == 0) check("error_cleared_on_start", error_o, 1'b0);
      if (active && rel >= 0 && exp_done_q.size() > 0 && rel < int'(exp_done_q[0]))
        check("busy_during_xfer", busy_o, 1'b1);

      // Data phase of the previously accepted beat.
      if (tb_pend) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_data_phase", 1'b1, 1'b0);
        end else if (hready_i) begin
          check("hwdata", hwdata_o, exp_data_q.pop_front());
        end else begin
          check("hwdata_hold", hwdata_o, exp_data_q[0]);
        end
      end

      // Address phase.
      if (htrans_o == 2'b10) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_beat", haddr_o, 32'hdead_beef);
        end else if (hready_i) begin
          check("haddr", haddr_o, exp_addr_q.pop_front());
        end else begin
          check("haddr_hold", haddr_o, exp_addr_q[0]);
        end
      end
      tb_pend = acc || (tb_pend && !hready_i);

      if (done_o) begin
        done_total++;
        if (!active || exp_done_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          check("done_cycle", rel, exp_done_q.pop_front());
          check("done_error", error_o, exp_err_q.pop_front());
          check("pop_count", xfer_pops, exp_pops_q.pop_front());
          check("busy_low_at_done", busy_o, 1'b0);
          check("beats_left", exp_addr_q.size() + exp_data_q.size(), 0);
        end
        active = 1'b0;
      end
    end
  end

  // Driver helpers.
  task automatic fifo_drive(input logic gap);
    fifo_empty_i = gap || (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic expect_xfer(input logic [31:0] a0, input logic [31:0] step, input int n,
                             input logic [31:0] d0, input int done_cyc, input logic err,
                             input int pops);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(d0 + 32'(i));
    end
    for (int i = 0; i < pops; i++) begin
      exp_addr_q.push_back(a0 + step * 32'(i));
      exp_data_q.push_back(d0 + 32'(i));
    end
    exp_done_q.push_back(32'(done_cyc));
    exp_err_q.push_back({31'b0, err});
    exp_pops_q.push_back(32'(pops));
  endtask

  // Runs one transfer; masks give per-cycle stall/gap/error after the start edge.
  task automatic run(input logic [31:0] addr, input logic [15:0] len, input logic inc,
                     input logic [31:0] stall_m, input logic [31:0] gap_m,
                     input logic [31:0] resp_m, input int rst_cyc);
    int last_pops;
    int last_done;
    last_pops  = pop_total;
    last_done  = done_total;
    dst_addr_i = addr;
    len_i      = len;
    incr_i     = inc;
    start_i    = 1'b1;
    fifo_drive(1'b0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int j = 0; j < 70; j++) begin
      while (pop_total != last_pops) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        last_pops++;
      end
      hready_i = (j < 32) ? !stall_m[j] : 1'b1;
      hresp_i  = (j < 32) ? resp_m[j] : 1'b0;
      fifo_drive((j < 32) ? gap_m[j] : 1'b0);
      if (j == rst_cyc) begin
        #1;
        areset = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done_q.delete();
        exp_err_q.delete();
        exp_pops_q.delete();
        fifo_q.delete();
        break;
      end
      @(posedge clk);
      #1;
      if (done_total != last_done) break;
    end
    while (pop_total != last_pops) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      last_pops++;
    end
    hready_i = 1'b1;
    hresp_i  = 1'b0;
    fifo_drive(1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    areset     = 1'b0;
    start_i    = 1'b0;
    dst_addr_i = 32'h0;
    len_i      = 16'h0;
    incr_i     = 1'b0;
    hready_i   = 1'b1;
    hresp_i    = 1'b0;
    fifo_drive(1'b0);
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b1;
    @(posedge clk);
    #1;

    // Incrementing, zero wait: done at E0+5.
    expect_xfer(32'h1000, 32'h4, 4, 32'hAAAA_0001, 5, 1'b0, 4);
    run(32'h1000, 16'd4, 1'b1, 32'h0, 32'h0, 32'h0, -1);

    // Two wait states on the second data phase (cycles 2,3): done delayed to 6.
    expect_xfer(32'h3000, 32'h4, 3, 32'hBBBB_0001, 6, 1'b0, 3);
    run(32'h3000, 16'd3, 1'b1, 32'h0000_000C, 32'h0, 32'h0, -1);

    // FIFO empty for 3 cycles after word 2 (cycles 2..4): done at 8.
    expect_xfer(32'h4000, 32'h4, 4, 32'hCCCC_0001, 8, 1'b0, 4);
    run(32'h4000, 16'd4, 1'b1, 32'h0, 32'h0000_001C, 32'h0, -1);

    // Fixed address.
    expect_xfer(32'h2000, 32'h0, 3, 32'hDDDD_0001, 4, 1'b0, 3);
    run(32'h2000, 16'd3, 1'b0, 32'h0, 32'h0, 32'h0, -1);

    // ERROR on the data phase of beat index 2 (cycles 3,4): three pops, done at 5.
    expect_xfer(32'h5000, 32'h4, 5, 32'hEEEE_0001, 5, 1'b1, 3);
    run(32'h5000, 16'd5, 1'b1, 32'h0000_0008, 32'h0, 32'h0000_0018, -1);
    fifo_q.delete();

    // Next start clears the sticky error.
    expect_xfer(32'h6000, 32'h4, 2, 32'h1111_0001, 3, 1'b0, 2);
    run(32'h6000, 16'd2, 1'b1, 32'h0, 32'h0, 32'h0, -1);

    // Zero-length start: done in cycle 0, no beats, no pops.
    expect_xfer(32'h0, 32'h4, 0, 32'h0, 0, 1'b0, 0);
    run(32'h7777_0000, 16'd0, 1'b1, 32'h0, 32'h0, 32'h0, -1);

    // Reset in the middle of a transfer.
    expect_xfer(32'h7000, 32'h4, 4, 32'h2222_0001, 5, 1'b0, 4);
    run(32'h7000, 16'd4, 1'b1, 32'h0, 32'h0, 32'h0, 2);

    // Clean run after reset, crossing the top of the address space.
    expect_xfer(32'hFFFF_FFFC, 32'h4, 2, 32'h3333_0001, 3, 1'b0, 2);
    run(32'hFFFF_FFFC, 16'd2, 1'b1, 32'h0, 32'h0, 32'h0, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
